// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot loader: framed byte stream to instruction memory, gates core reset
// Frame: L0 L1 (word count, LE), 4*N data bytes (LE words), XOR checksum byte.
module prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         word_q, word_d;
  logic [1:0]          byte_q, byte_d;
  logic [7:0]          xor_q, xor_d;
  logic [23:0]         shift_q, shift_d;
  logic                rx_ready_q, rx_ready_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                xfer, wr_fire, load_start;
  logic [15:0]         len_full;

  assign xfer     = rx_valid & rx_ready_q;
  assign len_full = {rx_data, len_q[7:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      word_q       <= '0;
      byte_q       <= '0;
      xor_q        <= '0;
      shift_q      <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_rst_q    <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_q       <= word_d;
      byte_q       <= byte_d;
      xor_q        <= xor_d;
      shift_q      <= shift_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_d     = word_q;
    byte_d     = byte_q;
    xor_d      = xor_q;
    shift_d    = shift_q;
    wr_fire    = 1'b0;
    load_start = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          load_start = 1'b1;
          state_d    = S_LEN0;
          word_d     = '0;
          byte_d     = '0;
          xor_d      = '0;
        end
      end
      S_LEN0: begin
        if (xfer) begin
          len_d   = {8'h00, rx_data};
          xor_d   = xor_q ^ rx_data;
          state_d = S_LEN1;
        end
      end
      S_LEN1: begin
        if (xfer) begin
          len_d = len_full;
          xor_d = xor_q ^ rx_data;
          if (len_full > MAX_N)       state_d = S_ERROR;
          else if (len_full == 16'd0) state_d = S_CHECK;
          else                        state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          xor_d   = xor_q ^ rx_data;
          // Bytes enter at the top so b0 ends up in bits 7:0 after three shifts.
          shift_d = {rx_data, shift_q[23:8]};
          byte_d  = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            wr_fire = 1'b1;
            word_d  = word_q + 16'd1;
            if (word_q + 16'd1 == len_q) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (xfer) state_d = (rx_data == xor_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready_d   = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                   (state_d == S_DATA) || (state_d == S_CHECK);
    busy_d       = rx_ready_d;
    done_d       = (state_d == S_DONE);
    err_d        = (state_d == S_ERROR);
    cpu_rst_d    = (state_d != S_DONE);
    imem_we_d    = wr_fire;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    if (load_start) imem_addr_d = '0;
    if (wr_fire) begin
      imem_addr_d  = word_q[ADDR_W-1:0];
      imem_wdata_d = {rx_data, shift_q};
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
